// File: rtl/issue_trace.sv
// Issue-bus trace buffer: fill-stop or circular capture with post-trigger window, stamped entries.
// Write on the sampled edge, head entry on rd_* combinationally in DONE; drain holds while rd_ready is low.
`ifndef WIDTH_CMD
`define WIDTH_CMD 8
`endif

module issue_trace #(
    parameter int CHANNELS    = 3,
    parameter int CMD_WIDTH   = `WIDTH_CMD,
    parameter int DEPTH       = 16,
    parameter int STAMP_WIDTH = 16,
    parameter int POST        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          trig,
    input  logic [1:0]                    mode,
    input  logic [CHANNELS-1:0]           ch_valid,
    input  logic [CHANNELS*CMD_WIDTH-1:0] ch_cmd,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [STAMP_WIDTH-1:0]        rd_stamp,
    output logic [CHANNELS-1:0]           rd_mask,
    output logic [CHANNELS*CMD_WIDTH-1:0] rd_cmd,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          done
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_LAST = (PW+1)'(DEPTH - 1);
    localparam logic [PW-1:0] POST_LD  = PW'(POST);

    typedef struct packed {
        logic [STAMP_WIDTH-1:0]        stamp;
        logic [CHANNELS-1:0]           mask;
        logic [CHANNELS*CMD_WIDTH-1:0] cmd;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_POST,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [STAMP_WIDTH-1:0] stamp;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          post_cnt;
    logic [PW-1:0]          post_nxt;
    logic                   qual_mode;
    logic                   circ_mode;
    logic                   active;
    logic                   sample;
    logic                   wr_en;
    logic                   full;
    logic                   pop;
    entry_t                 mem [DEPTH];
    entry_t                 head;

    assign active = (state == S_CAPTURE) || (state == S_POST);
    // start and stop cycles are never captured; start restarts, stop terminates
    assign sample = active && !start && !stop && (!qual_mode || (|ch_valid));
    assign full   = (count == CNT_FULL);
    assign wr_en  = sample && (!full || circ_mode);
    assign pop    = rd_valid && rd_ready;

    assign head     = mem[rd_ptr];
    assign rd_valid = (state == S_DONE) && (count != '0);
    assign rd_stamp = head.stamp;
    assign rd_mask  = head.mask;
    assign rd_cmd   = head.cmd;
    assign busy     = active;
    assign done     = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        post_nxt  = post_cnt;
        if (start) begin
            state_nxt = S_CAPTURE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_IDLE;
                end
                S_CAPTURE: begin
                    if (stop) begin
                        state_nxt = S_DONE;
                    end else if (!circ_mode) begin
                        if (wr_en && (count == CNT_LAST)) state_nxt = S_DONE;
                    end else if (trig) begin
                        if (POST == 0) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_POST;
                            post_nxt  = POST_LD;
                        end
                    end
                end
                S_POST: begin
                    if (stop) begin
                        state_nxt = S_DONE;
                    end else if (wr_en) begin
                        post_nxt = post_cnt - 1'b1;
                        if (post_cnt == PW'(1)) state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if ((count == '0) || (pop && (count == (PW+1)'(1)))) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            stamp     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            post_cnt  <= '0;
            qual_mode <= 1'b0;
            circ_mode <= 1'b0;
        end else begin
            state    <= state_nxt;
            post_cnt <= post_nxt;
            stamp    <= stamp + 1'b1;
            if (start) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                qual_mode <= mode[0];
                circ_mode <= mode[1];
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                // a write into a full circular buffer drops the oldest entry
                if (full) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{stamp: stamp, mask: ch_valid, cmd: ch_cmd};
        end
    end

endmodule

// File: tb/tb_issue_trace.sv
// Bench for issue_trace: a 16-deep instance (POST=8) and a 4-deep, 4-bit-stamp instance (POST=0) share stimulus.
module tb_issue_trace;
    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        trig;
    logic [1:0]  mode;
    logic [2:0]  ch_valid;
    logic [23:0] ch_cmd;

    logic        rd_ready_a, rd_valid_a, overflow_a, busy_a, done_a;
    logic [15:0] rd_stamp_a;
    logic [2:0]  rd_mask_a;
    logic [23:0] rd_cmd_a;
    logic [4:0]  count_a;

    logic        rd_ready_b, rd_valid_b, overflow_b, busy_b, done_b;
    logic [3:0]  rd_stamp_b;
    logic [2:0]  rd_mask_b;
    logic [23:0] rd_cmd_b;
    logic [2:0]  count_b;

    logic [15:0] cyc;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    issue_trace #(.CHANNELS(3), .CMD_WIDTH(8), .DEPTH(16), .STAMP_WIDTH(16), .POST(8)) u_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .trig(trig), .mode(mode),
        .ch_valid(ch_valid), .ch_cmd(ch_cmd), .rd_valid(rd_valid_a), .rd_ready(rd_ready_a),
        .rd_stamp(rd_stamp_a), .rd_mask(rd_mask_a), .rd_cmd(rd_cmd_a), .count(count_a),
        .overflow(overflow_a), .busy(busy_a), .done(done_a)
    );

    issue_trace #(.CHANNELS(3), .CMD_WIDTH(8), .DEPTH(4), .STAMP_WIDTH(4), .POST(0)) u_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .trig(trig), .mode(mode),
        .ch_valid(ch_valid), .ch_cmd(ch_cmd), .rd_valid(rd_valid_b), .rd_ready(rd_ready_b),
        .rd_stamp(rd_stamp_b), .rd_mask(rd_mask_b), .rd_cmd(rd_cmd_b), .count(count_b),
        .overflow(overflow_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference cycle stamp: value seen by the sample taken at the next rising edge
    always @(posedge clk) begin
        if (rst) cyc <= 16'd0;
        else     cyc <= cyc + 16'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ent_a(input logic [15:0] s, input logic [2:0] m, input logic [23:0] c);
        return {21'd0, s, m, c};
    endfunction

    function automatic logic [63:0] ent_b(input logic [3:0] s, input logic [2:0] m, input logic [23:0] c);
        return {33'd0, s, m, c};
    endfunction

    task automatic kick(input logic [1:0] m, input bit with_stop);
        start = 1'b1;
        stop  = with_stop;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic drive_random();
        ch_valid = 3'($urandom);
        ch_cmd   = 24'($urandom);
    endtask

    task automatic drain(input bit use_b, input bit toggle, input string tag);
        int          guard = 0;
        bit          phase = 1'b1;
        logic        rdy;
        logic        vld;
        logic [63:0] got;
        logic [63:0] exp;
        while (((use_b ? qb.size() : qa.size()) != 0) && guard < 200) begin
            rdy = toggle ? phase : 1'b1;
            if (use_b) rd_ready_b = rdy;
            else       rd_ready_a = rdy;
            #1;
            vld = use_b ? rd_valid_b : rd_valid_a;
            got = use_b ? ent_b(rd_stamp_b, rd_mask_b, rd_cmd_b) : ent_a(rd_stamp_a, rd_mask_a, rd_cmd_a);
            check({tag, "_count"}, use_b ? 64'(count_b) : 64'(count_a),
                  use_b ? 64'(qb.size()) : 64'(qa.size()));
            check({tag, "_rd_valid"}, 64'(vld), 64'd1);
            if (vld && rdy) begin
                exp = use_b ? qb.pop_front() : qa.pop_front();
                check({tag, "_entry"}, got, exp);
            end
            phase = !phase;
            guard++;
            @(negedge clk);
        end
        rd_ready_a = 1'b0;
        rd_ready_b = 1'b0;
        if (guard >= 200) check({tag, "_drain_timeout"}, 64'd0, 64'd1);
        check({tag, "_idle_done"}, use_b ? 64'(done_b) : 64'(done_a), 64'd0);
        check({tag, "_idle_busy"}, use_b ? 64'(busy_b) : 64'(busy_a), 64'd0);
        check({tag, "_idle_count"}, use_b ? 64'(count_b) : 64'(count_a), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] pats [4];
        int         g;
        pats[0] = 3'b000; pats[1] = 3'b101; pats[2] = 3'b000; pats[3] = 3'b010;
        rst = 1'b1; start = 1'b0; stop = 1'b0; trig = 1'b0; mode = 2'b00;
        ch_valid = '0; ch_cmd = '0; rd_ready_a = 1'b0; rd_ready_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", 64'(count_a), 64'd0);
        check("rst_overflow", 64'(overflow_a), 64'd0);
        check("rst_rd_valid", 64'(rd_valid_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // fill-stop, qualify off
        kick(2'b00, 1'b0);
        check("t1_busy", 64'(busy_a), 64'd1);
        for (int i = 0; i < 20; i++) begin
            if (i == 15) check("t1_done_early", 64'(done_a), 64'd0);
            if (i == 16) check("t1_done", 64'(done_a), 64'd1);
            drive_random();
            if (i < 16) qa.push_back(ent_a(cyc, ch_valid, ch_cmd));
            @(negedge clk);
        end
        check("t1_count", 64'(count_a), 64'd16);
        check("t1_overflow", 64'(overflow_a), 64'd0);
        drain(1'b0, 1'b0, "t1");

        // qualify on, stop cycle not captured, toggling drain
        kick(2'b01, 1'b0);
        for (int i = 0; i < 20; i++) begin
            ch_valid = pats[i % 4];
            ch_cmd   = 24'($urandom);
            if (ch_valid != 3'b000) qa.push_back(ent_a(cyc, ch_valid, ch_cmd));
            @(negedge clk);
        end
        stop = 1'b1; ch_valid = 3'b111;
        @(negedge clk);
        stop = 1'b0;
        check("t2_done", 64'(done_a), 64'd1);
        check("t2_count", 64'(count_a), 64'd10);
        drain(1'b0, 1'b1, "t2");

        // circular with post window; second trigger inside POST is ignored
        kick(2'b10, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i == 38) check("t3_done_early", 64'(done_a), 64'd0);
            if (i == 39) check("t3_done", 64'(done_a), 64'd1);
            trig = (i == 30) || (i == 34);
            drive_random();
            if (i <= 38) qa.push_back(ent_a(cyc, ch_valid, ch_cmd));
            @(negedge clk);
        end
        trig = 1'b0;
        while (qa.size() > 16) void'(qa.pop_front());
        check("t3_count", 64'(count_a), 64'd16);
        check("t3_overflow", 64'(overflow_a), 64'd1);
        drain(1'b0, 1'b0, "t3");

        // reset mid-drain with five entries left
        kick(2'b00, 1'b0);
        for (int i = 0; i < 17; i++) begin
            drive_random();
            @(negedge clk);
        end
        rd_ready_a = 1'b1;
        repeat (11) @(negedge clk);
        rd_ready_a = 1'b0;
        check("t4_count_before", 64'(count_a), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_count", 64'(count_a), 64'd0);
        check("t4_done", 64'(done_a), 64'd0);
        check("t4_busy", 64'(busy_a), 64'd0);
        check("t4_rd_valid", 64'(rd_valid_a), 64'd0);

        // start and stop together: start wins; empty DONE returns to IDLE
        kick(2'b00, 1'b1);
        check("t5_busy", 64'(busy_a), 64'd1);
        check("t5_not_done", 64'(done_a), 64'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t5_done", 64'(done_a), 64'd1);
        check("t5_count", 64'(count_a), 64'd0);
        @(negedge clk);
        check("t5_idle_done", 64'(done_a), 64'd0);
        check("t5_idle_busy", 64'(busy_a), 64'd0);

        // 4-bit stamp wrap on the small instance: 14, 15, 0, 1
        g = 0;
        while (cyc[3:0] != 4'd13 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) check("t6_align_timeout", 64'd0, 64'd1);
        kick(2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_random();
            if (i < 4) qb.push_back(ent_b(cyc[3:0], ch_valid, ch_cmd));
            @(negedge clk);
        end
        check("t6_first_stamp", 64'(rd_stamp_b), 64'd14);
        drain(1'b1, 1'b0, "t6");

        // circular with POST=0: DONE right after the trigger cycle
        kick(2'b10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 7) check("t7_done_early", 64'(done_b), 64'd0);
            if (i == 8) check("t7_done", 64'(done_b), 64'd1);
            trig = (i == 7);
            drive_random();
            if (i <= 7) qb.push_back(ent_b(cyc[3:0], ch_valid, ch_cmd));
            @(negedge clk);
        end
        trig = 1'b0;
        while (qb.size() > 4) void'(qb.pop_front());
        check("t7_count", 64'(count_b), 64'd4);
        check("t7_overflow", 64'(overflow_b), 64'd1);
        drain(1'b1, 1'b1, "t7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
